// File: rtl/hit_alarm_pkg.sv
// Shared types and helpers for the hit alarm controller.
package hit_alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BLANK   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_ALARM   = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  // Width of the shared blank/holdoff down-counter; never narrower than 1 bit.
  function automatic int timer_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hit_alarm_ctrl_hold_timer.sv
// Loadable down-counter shared by the BLANK and HOLDOFF states.
module hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hit_alarm_ctrl.sv
// Arming/alarm sequencer for the seqcheck detector: blanking, held alarm with ack, holdoff, counters.
module hit_alarm_ctrl
  import hit_alarm_pkg::*;
#(
  parameter int ARM_DELAY   = 8,
  parameter int HOLDOFF_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             disarm,
  input  logic             hit,
  input  logic             alarm_ack,
  input  logic             clr_cnt,
  output logic             det_en,
  output logic             alarm_valid,
  output logic [CNT_W-1:0] alarm_count,
  output logic [CNT_W-1:0] missed_count,
  output logic [2:0]       state
);

  localparam int               TW      = timer_w(ARM_DELAY, HOLDOFF_CYC);
  localparam logic [TW-1:0]    BLANK_LD = TW'(ARM_DELAY - 1);
  localparam logic [TW-1:0]    HOLD_LD  = TW'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t        state_q, state_n;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_load_val;
  logic          alarm_inc, missed_inc;

  hold_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    alarm_inc    = 1'b0;
    missed_inc   = 1'b0;
    if (disarm) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_n      = ST_BLANK;
            tmr_load     = 1'b1;
            tmr_load_val = BLANK_LD;
          end
        end
        ST_BLANK: begin
          if (tmr_zero) state_n = ST_ARMED;
          else          tmr_dec = 1'b1;
        end
        ST_ARMED: begin
          if (hit) begin
            state_n   = ST_ALARM;
            alarm_inc = 1'b1;
          end
        end
        ST_ALARM: begin
          missed_inc = hit;
          if (alarm_ack) begin
            state_n      = ST_HOLDOFF;
            tmr_load     = 1'b1;
            tmr_load_val = HOLD_LD;
          end
        end
        ST_HOLDOFF: begin
          missed_inc = hit;
          if (tmr_zero) state_n = ST_ARMED;
          else          tmr_dec = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Outputs are flopped alongside the state so they carry no combinational input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      det_en      <= 1'b0;
      alarm_valid <= 1'b0;
    end else begin
      state_q     <= state_n;
      det_en      <= (state_n != ST_IDLE);
      alarm_valid <= (state_n == ST_ALARM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_count  <= '0;
      missed_count <= '0;
    end else if (clr_cnt) begin
      alarm_count  <= '0;
      missed_count <= '0;
    end else begin
      if (alarm_inc && (alarm_count != CNT_MAX))   alarm_count  <= alarm_count + 1'b1;
      if (missed_inc && (missed_count != CNT_MAX)) missed_count <= missed_count + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hit_alarm_ctrl.sv
// Self-checking bench: directed scenarios then random stimulus against a timestamp-based model.
module tb_hit_alarm_ctrl;
  localparam int AD = 8;
  localparam int HD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm = 1'b0, disarm = 1'b0, hit = 1'b0, alarm_ack = 1'b0, clr_cnt = 1'b0;

  logic       det_en, alarm_valid;
  logic [7:0] alarm_count, missed_count;
  logic [2:0] state;
  logic       s_det_en, s_alarm_valid;
  logic [1:0] s_alarm_count, s_missed_count;
  logic [2:0] s_state;

  hit_alarm_ctrl #(.ARM_DELAY(AD), .HOLDOFF_CYC(HD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .hit(hit),
    .alarm_ack(alarm_ack), .clr_cnt(clr_cnt), .det_en(det_en),
    .alarm_valid(alarm_valid), .alarm_count(alarm_count),
    .missed_count(missed_count), .state(state)
  );

  hit_alarm_ctrl #(.ARM_DELAY(AD), .HOLDOFF_CYC(HD), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .hit(hit),
    .alarm_ack(alarm_ack), .clr_cnt(clr_cnt), .det_en(s_det_en),
    .alarm_valid(s_alarm_valid), .alarm_count(s_alarm_count),
    .missed_count(s_missed_count), .state(s_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: modes 0..4 named as the spec's states; timed states keep the
  // absolute cycle at which ARMED is reached rather than a countdown.
  int now, mode, ready, ac, mc, ac_s, mc_s;

  function automatic int mstate(input int t);
    if ((mode == 1 || mode == 4) && t >= ready) return 2;
    return mode;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    now = 0; mode = 0; ready = 0; ac = 0; mc = 0; ac_s = 0; mc_s = 0;
  endtask

  task automatic model_edge();
    int cur;
    cur = mstate(now);
    if (disarm) begin
      mode = 0;
    end else begin
      case (cur)
        0: if (arm) begin mode = 1; ready = now + 1 + AD; end
        2: begin
          mode = 2;
          if (hit) begin mode = 3; ac = sat(ac, 255); ac_s = sat(ac_s, 3); end
        end
        3: begin
          if (hit) begin mc = sat(mc, 255); mc_s = sat(mc_s, 3); end
          if (alarm_ack) begin mode = 4; ready = now + 1 + HD; end
        end
        4: if (hit) begin mc = sat(mc, 255); mc_s = sat(mc_s, 3); end
        default: ;
      endcase
    end
    if (clr_cnt) begin ac = 0; mc = 0; ac_s = 0; mc_s = 0; end
    now++;
  endtask

  task automatic compare_all();
    int st;
    st = mstate(now);
    check("state", state, st);
    check("det_en", det_en, (st != 0));
    check("alarm_valid", alarm_valid, (st == 3));
    check("alarm_count", alarm_count, ac);
    check("missed_count", missed_count, mc);
    check("s_state", s_state, st);
    check("s_alarm_count", s_alarm_count, ac_s);
    check("s_missed_count", s_missed_count, mc_s);
  endtask

  // Drives one cycle's inputs from a negedge, applies the edge, and compares at the next negedge.
  task automatic step(input logic a, input logic d, input logic h, input logic k, input logic c);
    arm = a; disarm = d; hit = h; alarm_ack = k; clr_cnt = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int n0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_det_en", det_en, 0);
    check("rst_alarm_valid", alarm_valid, 0);
    rst_n = 1'b1;

    // Arm at cycle 10, ignored hit at 14, ARMED at 19.
    idle(10);
    step(1, 0, 0, 0, 0);
    check("blank_det_en", det_en, 1);
    idle(3);
    step(0, 0, 1, 0, 0);
    idle(3);
    check("blank_c18", state, 1);
    idle(1);
    check("armed_c19", now, 19);
    check("armed_state", state, 2);
    check("blank_missed", missed_count, 0);
    check("blank_alarm", alarm_count, 0);

    // Handshake with missed hits in ALARM (incl. ack cycle) and HOLDOFF (incl. last cycle).
    n0 = now;
    step(0, 0, 1, 0, 0);
    check("alarm_valid_n1", alarm_valid, 1);
    check("alarm_count_n1", alarm_count, 1);
    for (int i = 1; i <= 21; i++) begin
      step(0, 0, (i == 2 || i == 3 || i == 5 || i == 8 || i == 21), (i == 5), 0);
      if (i == 5)  check("ack_drop", alarm_valid, 0);
      if (i == 20) check("holdoff_n21", state, 4);
    end
    check("armed_n22", now - n0, 22);
    check("rearmed_state", state, 2);
    check("missed_total", missed_count, 5);
    check("alarm_total", alarm_count, 1);

    // Disarm beats arm and ack in ALARM.
    step(0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    check("disarm_state", state, 0);
    check("disarm_valid", alarm_valid, 0);
    check("disarm_det_en", det_en, 0);
    check("disarm_counts", alarm_count, 2);

    // Five alarms saturate the 2-bit counter.
    for (int r = 0; r < 5; r++) begin
      step(1, 0, 0, 0, 0);
      idle(AD);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
    end
    check("sat_small", s_alarm_count, 3);
    check("sat_wide", alarm_count, 7);

    // Clear coincident with an accepted hit.
    step(1, 0, 0, 0, 0);
    idle(AD);
    step(0, 0, 1, 0, 1);
    check("clr_alarm", alarm_count, 0);
    check("clr_small", s_alarm_count, 0);
    check("clr_valid", alarm_valid, 1);

    // Async reset while the alarm is held.
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_valid", alarm_valid, 0);
    check("arst_det_en", det_en, 0);
    check("arst_counts", {alarm_count, missed_count}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(3) == 0), ($urandom_range(59) == 0), ($urandom_range(2) == 0),
           ($urandom_range(3) == 0), ($urandom_range(79) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hit_alarm_ctrl.md
# hit_alarm_ctrl

Arming and alarm controller sitting directly downstream of the windowed rise-count checker (`seqcheck`). Sequences the checker's enable, blanks its output while its synchronizer and 5-cycle window flush, converts single-cycle `hit` pulses into a held alarm with a valid/ack handshake, and enforces a post-alarm holdoff. Maintains saturating counts of accepted alarms and of hits dropped while busy.

## Interface
Parameters:
- `ARM_DELAY`, 8: blanking cycles after arming; legal range ≥1. The default covers the 3-stage synchronizer/edge pipeline plus the 5-cycle window.
- `HOLDOFF_CYC`, 16: cycles after ack before re-arming; legal range ≥1.
- `CNT_W`, 8: width of `alarm_count` and `missed_count`.

Ports:
- `clk`, input, 1: single clock; all logic rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `arm`, input, 1: start-monitoring pulse; honoured only in IDLE.
- `disarm`, input, 1: return to IDLE from any state.
- `hit`, input, 1: one-cycle detection pulse from the checker.
- `alarm_ack`, input, 1: consumer acknowledge.
- `clr_cnt`, input, 1: synchronous clear of both counters.
- `det_en`, output, 1: enable to the checker.
- `alarm_valid`, output, 1: alarm pending.
- `alarm_count`, output, CNT_W: accepted alarms, saturating.
- `missed_count`, output, CNT_W: hits in ALARM or HOLDOFF, saturating.
- `state`, output, 3: current FSM state for debug.

## Operation
FSM states and encodings: IDLE=0, BLANK=1, ARMED=2, ALARM=3, HOLDOFF=4. A single down-counter `timer` of width clog2(max(ARM_DELAY, HOLDOFF_CYC)) serves both timed states.
- **IDLE**: `det_en`=0 and `hit` is ignored. On `arm`, go to BLANK and load `timer`=ARM_DELAY-1.
- **BLANK**: `det_en`=1. `hit` is ignored and not counted. When `timer`=0, go to ARMED; otherwise decrement.
- **ARMED**: `det_en`=1. On `hit`, go to ALARM and increment `alarm_count`.
- **ALARM**: `alarm_valid`=1, `det_en`=1.
  - On `alarm_ack`, go to HOLDOFF and load `timer`=HOLDOFF_CYC-1.
  - Each `hit` increments `missed_count`.
- **HOLDOFF**: `det_en`=1.
  - Each `hit` increments `missed_count`.
  - When `timer`=0, go to ARMED; otherwise decrement.

Priority and boundary rules:
- Priority is `disarm` > `arm` > `alarm_ack` > `hit`. `disarm` in any state gives IDLE next cycle, drops `alarm_valid`, and does not alter the counters.
- `arm` and `disarm` in the same cycle: stay in or go to IDLE.
- `arm` outside IDLE is ignored; it does not restart blanking.
- `alarm_ack` outside ALARM is ignored.
- A `hit` in the same cycle as `alarm_ack` in ALARM is counted as missed.
- A `hit` in HOLDOFF on the cycle `timer`=0 is counted as missed; ARMED is still entered.
- Counters saturate at 2^CNT_W-1 and never wrap.
- `clr_cnt` wins over a same-cycle increment: the counter becomes 0.
- `alarm_valid`, `det_en` and `state` are registered. They are decoded from the registered state, with no combinational path from inputs.

## Timing
- Reset values: `state`=IDLE, `det_en`=0, `alarm_valid`=0, `alarm_count`=0, `missed_count`=0, `timer`=0.
- Reset mid-operation, including while `alarm_valid`=1, returns every output to these values immediately. No alarm is remembered.
- `arm` at cycle A: `det_en`=1 from A+1; ARMED from A+1+ARM_DELAY.
- `hit` at cycle N while ARMED: `alarm_valid`=1 and `alarm_count` incremented at N+1.
- `alarm_ack` at cycle M while `alarm_valid`=1: `alarm_valid`=0 at M+1; ARMED at M+1+HOLDOFF_CYC.
- The ack may arrive in the first cycle `alarm_valid` is high.
- `alarm_valid` stays high indefinitely until ack or `disarm`.
- `disarm` at cycle D: IDLE and `det_en`=0 at D+1.

## Structure
- Package `hit_alarm_pkg` holds the state enum with the encodings above.
- Sub-module `hold_timer`: loadable down-counter with `load`, `load_val` and `zero` flag, instantiated once.
- Counter saturation is inline.

## Test plan
- **Arm and blank:** reset, then `arm` at cycle 10 and `hit` at cycle 14 → no alarm, `missed_count`=0. `state` is ARMED at cycle 19.
- **Alarm handshake:** ARMED, `hit` at N → `alarm_valid`=1 at N+1, `alarm_count`=1. `alarm_ack` at N+5 → `alarm_valid`=0 at N+6, ARMED at N+22.
- **Missed hits:** hits at 3 cycles during ALARM and 2 during HOLDOFF, one of them on the ack cycle → `missed_count`=5, `alarm_count`=1.
- **Disarm priority:** `disarm`, `arm` and `alarm_ack` together while in ALARM → IDLE next cycle, `alarm_valid`=0, `det_en`=0.
- **Saturation and clear:** CNT_W=2 with 5 alarm cycles → `alarm_count`=3. `clr_cnt` coincident with a hit in ARMED → `alarm_count`=0, and `alarm_valid` still asserts.
- **Async reset mid-alarm:** `rst_n` low while `alarm_valid`=1 → all outputs at reset values before the next clock edge.
